pump_request_scheduler: RTL and testbench
=========================================

// Module: pump_request_scheduler
// PURPOSE
//   Shares one pump power budget between two pumps: only one pump runs at a time. Captures
//   per-pump run requests, grants them round-robin, holds the granted pump on for a
//   programmed number of seconds, then enforces a fixed dead-gap before the next grant.
//   Sits between the request sources (periodic timers, manual/force buttons, sensor logic)
//   and the pump driver outputs.
// PARAMETERS
//   CLOCK_FREQ   100_000_000  clk cycles per second; the internal 1 s tick is derived from it
//   GAP_SECONDS  2            mandatory all-off seconds after each completed run (0 = no gap)
// PORTS
//   clk         in   1   system clock; all logic on posedge
//   rst_n       in   1   asynchronous, active-low reset
//   req         in   2   per-pump run request; a rising edge queues a run for that pump
//   on_time_s   in   16  run length in seconds; sampled on the grant edge
//   abort       in   1   rising edge stops everything and flushes the queue
//   pump_out    out  2   pump drive; one-hot or 2'b00, never 2'b11
//   busy        out  1   1 when state != IDLE
//   pending     out  2   queued-request flags
//   grant_done  out  1   one-cycle pulse when a run completes normally
// BEHAVIOUR
//   Reset: state=IDLE, pump_out=00, pending=00, busy=0, grant_done=0, req/abort edge regs=0,
//     rr pointer=1 (so pump 0 wins first), all counters 0. Asynchronous: pump_out drops
//     immediately, including mid-run.
//   Edge detect: req[i] high with previous sample low sets pending[i] on that edge.
//     An edge for a pump that is currently running re-queues it.
//   Tick: 32-bit prescaler counts 0..CLOCK_FREQ-1 and pulses sec_tick at CLOCK_FREQ-1.
//     Cleared on every entry to RUN or GAP, so N seconds = exactly N*CLOCK_FREQ cycles.
//     No multiplier is used; a 16-bit seconds counter counts ticks.
//   FSM IDLE -> RUN -> GAP -> IDLE:
//     IDLE: if pending!=00, select pump: the one not equal to rr if both pending, otherwise
//       the single pending pump. Clear its pending bit, latch on_time_s, set rr=selected.
//       If latched on_time_s==0: discard the request (pending bit cleared), stay IDLE,
//       rr unchanged, no pump, no grant_done.
//       Otherwise state=RUN and pump_out=onehot(sel) on the same edge.
//       Latency: pump_out rises on the 2nd clk edge after req is first sampled high.
//     RUN: pump_out held for on_time*CLOCK_FREQ cycles. On the final tick: pump_out=00,
//       grant_done=1 for one cycle, then state=GAP (GAP_SECONDS>0) or IDLE.
//     GAP: pump_out=00 for GAP_SECONDS*CLOCK_FREQ cycles, then IDLE. Requests still queue.
//   abort rising edge (any state): next edge sets state=IDLE, pump_out=00, pending=00,
//     prescaler/seconds=0, no grant_done, rr unchanged. abort beats a req edge in the
//     same cycle; that req edge is dropped.
//   Requests from both pumps in the same cycle: both pending bits set; served in rr order.
//   on_time_s changes during RUN have no effect until the next grant.
// CONFIGURATION
//   PUMP_RUN_COUNT_EN defined: adds output ports run_count0 and run_count1 (out, 16 bits
//     each). Each increments on that pump's grant_done and saturates at 16'hFFFF.
//     Cleared only by rst_n; abort does not clear them, and an aborted run does not count.
//   Not defined: those ports and counters do not exist; all other behaviour is identical.
// TESTING  (CLOCK_FREQ=10, GAP_SECONDS=2)
//   req=01 edge, on_time_s=3 -> pump_out=01 for 30 cycles starting 2 edges later;
//     grant_done pulses once; 20 cycles of 00 with busy=1; then busy=0.
//   After reset, req=11 in one cycle, on_time_s=1 -> pump 0 runs 10 cycles, gap 20,
//     pump 1 runs 10 cycles; pump_out never 11.
//   req[1] edge at cycle 5 of a pump-0 run -> pending=10; pump 1 starts on the first
//     edge after the 20-cycle gap.
//   abort edge at cycle 15 of a 30-cycle run with pending=10 -> pump_out=00 and
//     pending=00 one edge later; no grant_done; busy=0.
//   on_time_s=0, req=10 edge -> pending clears, pump_out stays 00, busy stays 0,
//     no grant_done.
//   rst_n low mid-RUN -> pump_out=00 without a clk edge; after release the block is IDLE
//     and ignores req held high until it sees a new rising edge.

Source files
------------

// File: rtl/pump_request_scheduler.sv
// Two-pump power-budget scheduler: latches run requests, grants round-robin, times the run, then a dead gap.
// Optional build macro PUMP_RUN_COUNT_EN adds saturating per-pump completed-run counters.
module pump_request_scheduler #(
    parameter int unsigned CLOCK_FREQ  = 100_000_000,
    parameter int unsigned GAP_SECONDS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  req_i,
    input  logic [15:0] on_time_s_i,
    input  logic        abort_i,
    output logic [1:0]  pump_out_o,
    output logic        busy_o,
    output logic [1:0]  pending_o,
`ifdef PUMP_RUN_COUNT_EN
    output logic [15:0] run_count0_o,
    output logic [15:0] run_count1_o,
`endif
    output logic        grant_done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [31:0] TICK_LAST = 32'(CLOCK_FREQ - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_SECONDS - 1);
    localparam bit          GAP_EN    = (GAP_SECONDS != 0);

    state_e      state_q, state_d;
    logic [1:0]  req_prev_q;
    logic        abort_prev_q;
    logic        edge_arm_q;
    logic [1:0]  pending_q, pending_d;
    logic        rr_q, rr_d;
    logic        sel_q, sel_d;
    logic [15:0] on_q, on_d;
    logic [31:0] presc_q, presc_d;
    logic [15:0] sec_q, sec_d;
    logic        grant_done_q, grant_done_d;

    logic [1:0]  req_edge;
    logic        abort_edge;
    logic        sec_tick;
    logic        pick;
    logic        grant_try;
    logic        grant_ok;
    logic        run_end;
    logic        gap_end;
    logic        enter_timed;

    // Edge detection is disarmed for the first cycle after reset so a level held through reset is not a new request.
    assign req_edge    = req_i & ~req_prev_q & {2{edge_arm_q}};
    assign abort_edge  = abort_i & ~abort_prev_q & edge_arm_q;
    assign sec_tick    = (presc_q == TICK_LAST);
    assign pick        = (pending_q == 2'b11) ? ~rr_q : pending_q[1];
    assign grant_try   = (state_q == IDLE) && (pending_q != 2'b00) && !abort_edge;
    assign grant_ok    = grant_try && (on_time_s_i != 16'd0);
    assign run_end     = (state_q == RUN) && sec_tick && (sec_q == on_q - 16'd1);
    assign gap_end     = (state_q == GAP) && sec_tick && (sec_q == GAP_LAST);
    assign enter_timed = (state_d != state_q) && (state_d != IDLE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort_edge) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (grant_ok) state_d = RUN;
                RUN:     if (run_end)  state_d = GAP_EN ? GAP : IDLE;
                GAP:     if (gap_end)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        pump_out_o = 2'b00;
        if (state_q == RUN) begin
            pump_out_o = sel_q ? 2'b10 : 2'b01;
        end
        busy_o       = (state_q != IDLE);
        pending_o    = pending_q;
        grant_done_o = grant_done_q;
    end

    // Datapath next-state: queue, round-robin pointer, latched run length and the seconds timebase.
    always_comb begin
        pending_d    = pending_q;
        rr_d         = rr_q;
        sel_d        = sel_q;
        on_d         = on_q;
        presc_d      = presc_q;
        sec_d        = sec_q;
        grant_done_d = 1'b0;
        if (abort_edge) begin
            pending_d = 2'b00;
            presc_d   = 32'd0;
            sec_d     = 16'd0;
        end else begin
            if (grant_try) begin
                pending_d[pick] = 1'b0;
            end
            pending_d = pending_d | req_edge;
            if (grant_ok) begin
                rr_d  = pick;
                sel_d = pick;
                on_d  = on_time_s_i;
            end
            grant_done_d = run_end;
            if (enter_timed || (state_q == IDLE)) begin
                presc_d = 32'd0;
                sec_d   = 16'd0;
            end else if (sec_tick) begin
                presc_d = 32'd0;
                sec_d   = sec_q + 16'd1;
            end else begin
                presc_d = presc_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_prev_q   <= 2'b00;
            abort_prev_q <= 1'b0;
            edge_arm_q   <= 1'b0;
            pending_q    <= 2'b00;
            rr_q         <= 1'b1;
            sel_q        <= 1'b0;
            on_q         <= 16'd0;
            presc_q      <= 32'd0;
            sec_q        <= 16'd0;
            grant_done_q <= 1'b0;
        end else begin
            req_prev_q   <= req_i;
            abort_prev_q <= abort_i;
            edge_arm_q   <= 1'b1;
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            sel_q        <= sel_d;
            on_q         <= on_d;
            presc_q      <= presc_d;
            sec_q        <= sec_d;
            grant_done_q <= grant_done_d;
        end
    end

`ifdef PUMP_RUN_COUNT_EN
    logic [15:0] run_cnt0_q, run_cnt1_q;

    // Only normal completions count; aborted or reset-interrupted runs never raise grant_done_d.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_cnt0_q <= 16'd0;
            run_cnt1_q <= 16'd0;
        end else if (grant_done_d) begin
            if (!sel_q && (run_cnt0_q != 16'hFFFF)) begin
                run_cnt0_q <= run_cnt0_q + 16'd1;
            end
            if (sel_q && (run_cnt1_q != 16'hFFFF)) begin
                run_cnt1_q <= run_cnt1_q + 16'd1;
            end
        end
    end

    assign run_count0_o = run_cnt0_q;
    assign run_count1_o = run_cnt1_q;
`endif

endmodule

// File: tb/tb_pump_request_scheduler.sv
// Scoreboard bench for pump_request_scheduler at CLOCK_FREQ=10, GAP_SECONDS=2.
module tb_pump_request_scheduler;

    localparam int CF  = 10;
    localparam int GAP = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] on_time = 16'd0;
    logic        abort = 1'b0;
    logic [1:0]  pump;
    logic        busy;
    logic [1:0]  pending;
    logic        gd;
`ifdef PUMP_RUN_COUNT_EN
    logic [15:0] rc0, rc1;
`endif

    pump_request_scheduler #(.CLOCK_FREQ(CF), .GAP_SECONDS(GAP)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .on_time_s_i  (on_time),
        .abort_i      (abort),
        .pump_out_o   (pump),
        .busy_o       (busy),
        .pending_o    (pending),
`ifdef PUMP_RUN_COUNT_EN
        .run_count0_o (rc0),
        .run_count1_o (rc1),
`endif
        .grant_done_o (gd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int pump;
        int len;
        bit done;
        int off;
    } run_t;

    run_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   gd_seen = 0;
    int   gd_exp = 0;
    int   bad11 = 0;
    int   rise_cyc = 0;
    int   fall_cyc = 0;
    int   run_pump = 0;
    logic [1:0] prev_pump = 2'b00;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp_v, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int p, input int len, input bit done, input int off);
        run_t r;
        r.pump = p;
        r.len  = len;
        r.done = done;
        r.off  = off;
        exp_q.push_back(r);
        if (done) gd_exp++;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 2000 && (busy !== 1'b0 || pending !== 2'b00); k++) step();
        if (k == 2000) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    // Run monitor: pops the expected run when the pump output drops and compares pump, length and completion.
    always @(negedge clk) begin
        run_t r;
        if (pump === 2'b11) bad11++;
        if (gd === 1'b1) gd_seen++;
        if (pump !== prev_pump) begin
            if (prev_pump != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_run", 1, 0);
                end else begin
                    r = exp_q.pop_front();
                    chk("run_pump", run_pump, r.pump);
                    chk("run_len", cyc - rise_cyc, r.len);
                    chk("run_done", {31'd0, gd}, {31'd0, r.done});
                end
                fall_cyc = cyc;
            end
            if (pump != 2'b00) begin
                rise_cyc = cyc;
                run_pump = pump[1] ? 1 : 0;
                if (exp_q.size() > 0 && exp_q[0].off > 0)
                    chk("gap_off", cyc - fall_cyc, exp_q[0].off);
            end
            prev_pump = pump;
        end
    end

    initial begin
        #500_000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        step(3);
        chk("rst_pump", pump, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_pending", pending, 2'b00);
        chk("rst_gd", gd, 1'b0);
        rst_n = 1'b1;
        step(2);

        // Single 3 s run on pump 0, with on_time changed mid-run.
        push(0, 30, 1'b1, 0);
        req = 2'b01; on_time = 16'd3;
        step();
        chk("lat_pump_pre", pump, 2'b00);
        chk("lat_pending", pending, 2'b01);
        step();
        chk("lat_pump", pump, 2'b01);
        chk("run_busy", busy, 1'b1);
        chk("grant_clears_pend", pending, 2'b00);
        req = 2'b00; on_time = 16'd7;
        step(29);
        chk("run_hold", pump, 2'b01);
        step();
        chk("end_pump", pump, 2'b00);
        chk("end_gd", gd, 1'b1);
        chk("gap_busy0", busy, 1'b1);
        step();
        chk("gd_one_cycle", gd, 1'b0);
        step(18);
        chk("gap_busy_last", busy, 1'b1);
        step();
        chk("gap_to_idle", busy, 1'b0);

        // Both requests in one cycle after reset: pump 0 first, then pump 1 after the gap.
        do_reset();
        push(0, 10, 1'b1, 0);
        push(1, 10, 1'b1, 21);
        req = 2'b11; on_time = 16'd1;
        step();
        chk("both_pending", pending, 2'b11);
        req = 2'b00;
        wait_idle();

        // Pump 1 requested during a pump 0 run: queued, served after the gap with the new length.
        push(0, 30, 1'b1, 0);
        push(1, 20, 1'b1, 21);
        req = 2'b01; on_time = 16'd3;
        step(2);
        chk("q_run_start", pump, 2'b01);
        req = 2'b00; on_time = 16'd2;
        step(4);
        req = 2'b10;
        step();
        chk("q_pending", pending, 2'b10);
        req = 2'b00;
        wait_idle();

        // Abort 15 cycles into a 30-cycle run with pump 1 queued.
        push(0, 15, 1'b0, 0);
        req = 2'b01; on_time = 16'd3;
        step(2);
        chk("ab_run_start", pump, 2'b01);
        req = 2'b00;
        step(3);
        req = 2'b10;
        step();
        chk("ab_pending_pre", pending, 2'b10);
        req = 2'b00;
        step(10);
        abort = 1'b1;
        step();
        chk("ab_pump", pump, 2'b00);
        chk("ab_pending", pending, 2'b00);
        chk("ab_busy", busy, 1'b0);
        chk("ab_gd", gd, 1'b0);
        abort = 1'b0;
        step(30);
        chk("ab_stays_idle", busy, 1'b0);

        // Abort edge and request edge together: the request is dropped.
        abort = 1'b1; req = 2'b01;
        step();
        chk("ab_beats_req", pending, 2'b00);
        step();
        chk("ab_beats_req_pump", pump, 2'b00);
        abort = 1'b0; req = 2'b00;
        step(2);

        // Zero run length: request discarded.
        on_time = 16'd0; req = 2'b10;
        step();
        chk("zero_pend_set", pending, 2'b10);
        step();
        chk("zero_pend_clr", pending, 2'b00);
        chk("zero_busy", busy, 1'b0);
        chk("zero_gd", gd, 1'b0);
        req = 2'b00;
        step(3);
        chk("zero_pump", pump, 2'b00);

        // Reset mid-run drops the pump without a clock edge; a held request is ignored afterwards.
        push(0, 3, 1'b0, 0);
        on_time = 16'd3; req = 2'b01;
        step(2);
        chk("rst_run_start", pump, 2'b01);
        step(3);
        rst_n = 1'b0;
        #1;
        chk("async_rst_pump", pump, 2'b00);
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("held_req_pump", pump, 2'b00);
        chk("held_req_pend", pending, 2'b00);
        chk("held_req_busy", busy, 1'b0);
        req = 2'b00;
        step();
        push(0, 10, 1'b1, 0);
        on_time = 16'd1; req = 2'b01;
        step(2);
        chk("new_edge_run", pump, 2'b01);
        req = 2'b00;
        wait_idle();
        step(2);

`ifdef PUMP_RUN_COUNT_EN
        chk("run_count0", rc0, 16'd1);
        chk("run_count1", rc1, 16'd0);
`endif
        chk("never_11", bad11, 0);
        chk("gd_total", gd_seen, gd_exp);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
